// File: rtl/mips_state_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mips_state_sequencer
// Description : Next-state engine for the multi-cycle MIPS32 controller.
//               Steps the current state number per opcode class (R, LW, SW,
//               BEQ, J), waits on data memory with a bounded timeout, halts
//               at instruction boundaries, traps illegal opcodes and counts
//               retired instructions.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               opcode[5:0]         - IR[31:26], used only in DECODE
//               mem_ready           - data memory access complete
//               halt                - stop at the next instruction boundary
//               state[5:0]          - current state number to the decoder
//               instr_done          - 1-cycle pulse, instruction retired
//               illegal_op          - high during the TRAP cycle
//               mem_timeout         - 1-cycle pulse, memory wait timed out
//               halted              - high while in IDLE
//               retired_count       - retired instruction count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_state_sequencer #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter int         WAIT_MAX = 8,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             halt,
  output logic [5:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [5:0] {
    S_FETCH  = 6'd0,
    S_DECODE = 6'd1,
    S_REXEC  = 6'd2,
    S_RWB    = 6'd3,
    S_BEQ    = 6'd4,
    S_ADDR   = 6'd5,
    S_MEMWR  = 6'd6,
    S_MEMRD  = 6'd7,
    S_LWWB   = 6'd8,
    S_JUMP   = 6'd9,
    S_TRAP   = 6'd10,
    S_IDLE   = 6'd11
  } state_e;

  // wait_cnt holds (in-state cycle number - 1), so its largest value is WAIT_MAX-1.
  localparam int                C_WAIT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(WAIT_MAX - 1);

  state_e             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [C_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic               instr_done_q, instr_done_d;
  logic               illegal_op_q, illegal_op_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   retired_count_q, retired_count_d;

  logic               w_retire;
  state_e             w_boundary;

  always_comb begin
    state_d       = S_FETCH;
    op_d          = op_q;
    wait_cnt_d    = wait_cnt_q;
    w_retire      = 1'b0;
    mem_timeout_d = 1'b0;
    w_boundary    = halt ? S_IDLE : S_FETCH;

    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        if (opcode == OP_RTYPE)                          state_d = S_REXEC;
        else if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_ADDR;
        else if (opcode == OP_BEQ)                       state_d = S_BEQ;
        else if (opcode == OP_J)                         state_d = S_JUMP;
        else                                             state_d = S_TRAP;
      end
      S_REXEC:  state_d = S_RWB;
      S_ADDR: begin
        // ADDR is the only way into the memory-wait states, so clear here.
        wait_cnt_d = '0;
        state_d    = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          if (state_q == S_MEMRD) begin
            state_d = S_LWWB;
          end else begin
            state_d  = w_boundary;
            w_retire = 1'b1;
          end
        end else if (wait_cnt_q == C_WAIT_LAST) begin
          state_d       = S_TRAP;
          mem_timeout_d = 1'b1;
        end else begin
          state_d    = state_q;
          wait_cnt_d = wait_cnt_q + C_WAIT_W'(1);
        end
      end
      S_RWB, S_BEQ, S_LWWB, S_JUMP: begin
        state_d  = w_boundary;
        w_retire = 1'b1;
      end
      S_TRAP:   state_d = w_boundary;
      S_IDLE:   state_d = halt ? S_IDLE : S_FETCH;
      default:  state_d = S_FETCH;
    endcase

    instr_done_d    = w_retire;
    retired_count_d = retired_count_q + (w_retire ? CNT_W'(1) : CNT_W'(0));
    illegal_op_d    = (state_d == S_TRAP);
    halted_d        = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_FETCH;
      op_q            <= '0;
      wait_cnt_q      <= '0;
      instr_done_q    <= 1'b0;
      illegal_op_q    <= 1'b0;
      mem_timeout_q   <= 1'b0;
      halted_q        <= 1'b0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      wait_cnt_q      <= wait_cnt_d;
      instr_done_q    <= instr_done_d;
      illegal_op_q    <= illegal_op_d;
      mem_timeout_q   <= mem_timeout_d;
      halted_q        <= halted_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign state         = state_q;
  assign instr_done    = instr_done_q;
  assign illegal_op    = illegal_op_q;
  assign mem_timeout   = mem_timeout_q;
  assign halted        = halted_q;
  assign retired_count = retired_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_state_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_state_sequencer
// Description : Self-checking bench for mips_state_sequencer. Each instruction
//               is expanded into its expected per-cycle state trace from the
//               opcode class, memory delay and halt choice; the DUT is driven
//               from that trace and compared cycle by cycle. A second copy
//               with a 4-bit counter exercises count wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_state_sequencer;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        halt;
  logic [5:0]  state, state4;
  logic        instr_done, illegal_op, mem_timeout, halted;
  logic        instr_done4, illegal_op4, mem_timeout4, halted4;
  logic [31:0] retired_count;
  logic [3:0]  retired_count4;

  always #5 clk = ~clk;

  mips_state_sequencer #(.WAIT_MAX(W), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .halt(halt),
    .state(state), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .halted(halted), .retired_count(retired_count)
  );

  mips_state_sequencer #(.WAIT_MAX(W), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .halt(halt),
    .state(state4), .instr_done(instr_done4), .illegal_op(illegal_op4),
    .mem_timeout(mem_timeout4), .halted(halted4), .retired_count(retired_count4)
  );

  typedef struct {
    logic [5:0] st;
    logic [5:0] opc;
    logic       mr;
    logic       hl;
    bit         retire;
    bit         tmo;
  } cyc_t;

  cyc_t        plan[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_cnt = 0;
  bit          prev_ret = 0;
  bit          prev_tmo = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom % 2);
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  task automatic push(input int st, input logic [5:0] opc, input logic mr,
                      input logic hl, input bit ret, input bit tmo);
    cyc_t c;
    c.st = 6'(st); c.opc = opc; c.mr = mr; c.hl = hl; c.retire = ret; c.tmo = tmo;
    plan.push_back(c);
  endtask

  // cls: 0=R 1=LW 2=SW 3=BEQ 4=J 5=illegal; k = cycles of mem_ready low before ready.
  task automatic build_plan(input int cls, input logic [5:0] opc, input int k,
                            input bit hend, input int idle_len);
    int   end_st;
    int   mem_st;
    logic end_mr;
    plan.delete();
    end_mr = rb();
    push(0, r6(), rb(), rb(), 0, 0);
    push(1, opc, rb(), rb(), 0, 0);
    case (cls)
      0: begin push(2, r6(), rb(), rb(), 0, 0); end_st = 3; end
      1, 2: begin
        push(5, r6(), rb(), rb(), 0, 0);
        mem_st = (cls == 1) ? 7 : 6;
        if (k < W) begin
          for (int i = 0; i < k; i++) push(mem_st, r6(), 1'b0, rb(), 0, 0);
          if (cls == 1) begin
            push(7, r6(), 1'b1, rb(), 0, 0);
            end_st = 8;
          end else begin
            end_st = 6;
            end_mr = 1'b1;
          end
        end else begin
          for (int i = 0; i < W - 1; i++) push(mem_st, r6(), 1'b0, rb(), 0, 0);
          push(mem_st, r6(), 1'b0, rb(), 0, 1);
          end_st = 10;
        end
      end
      3: end_st = 4;
      4: end_st = 9;
      default: end_st = 10;
    endcase
    push(end_st, r6(), end_mr, hend, (end_st != 10), 0);
    if (hend) begin
      for (int i = 0; i < idle_len - 1; i++) push(11, r6(), rb(), 1'b1, 0, 0);
      push(11, r6(), rb(), 1'b0, 0, 0);
    end
  endtask

  // rst_at >= 0 asserts reset during that cycle of the plan and abandons the rest.
  task automatic run_plan(input int rst_at);
    for (int i = 0; i < plan.size(); i++) begin
      check_eq("state", 32'(state), 32'(plan[i].st));
      check_eq("state4", 32'(state4), 32'(plan[i].st));
      check_eq("instr_done", 32'(instr_done), 32'(prev_ret));
      check_eq("mem_timeout", 32'(mem_timeout), 32'(prev_tmo));
      check_eq("illegal_op", 32'(illegal_op), 32'(plan[i].st == 6'd10));
      check_eq("halted", 32'(halted), 32'(plan[i].st == 6'd11));
      check_eq("retired_count", retired_count, model_cnt);
      check_eq("retired_count4", 32'(retired_count4), 32'(model_cnt[3:0]));
      opcode    = plan[i].opc;
      mem_ready = plan[i].mr;
      halt      = plan[i].hl;
      if (i == rst_at) rst = 1'b1;
      @(posedge clk);
      #1;
      if (i == rst_at) begin
        rst       = 1'b0;
        model_cnt = 0;
        prev_ret  = 0;
        prev_tmo  = 0;
        return;
      end
      prev_ret = plan[i].retire;
      prev_tmo = plan[i].tmo;
      if (plan[i].retire) model_cnt = model_cnt + 1;
    end
  endtask

  function automatic logic [5:0] illegal_opc();
    logic [5:0] o;
    do o = r6(); while (o == 6'h00 || o == 6'h23 || o == 6'h2B || o == 6'h04 || o == 6'h02);
    return o;
  endfunction

  initial begin
    int cls;
    logic [5:0] opc;
    rst = 1'b1; opcode = '0; mem_ready = 1'b0; halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed sequences.
    build_plan(0, 6'h00, 0, 0, 0);   run_plan(-1);  // R-type
    build_plan(1, 6'h23, 2, 0, 0);   run_plan(-1);  // LW with 2 wait cycles
    build_plan(2, 6'h2B, W, 0, 0);   run_plan(-1);  // SW timeout
    build_plan(5, 6'h3F, 0, 0, 0);   run_plan(-1);  // illegal opcode
    build_plan(0, 6'h00, 0, 1, 5);   run_plan(-1);  // halt at boundary, 5 idle
    build_plan(1, 6'h23, W, 0, 0);   run_plan(-1);  // LW timeout
    build_plan(2, 6'h2B, W - 1, 1, 2); run_plan(-1); // SW ready on last allowed cycle
    build_plan(1, 6'h23, 3, 0, 0);   run_plan(3);   // reset while in MEMRD
    build_plan(3, 6'h04, 0, 0, 0);   run_plan(-1);

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      cls = int'($urandom_range(0, 5));
      case (cls)
        0: opc = 6'h00;
        1: opc = 6'h23;
        2: opc = 6'h2B;
        3: opc = 6'h04;
        4: opc = 6'h02;
        default: opc = illegal_opc();
      endcase
      build_plan(cls, opc, int'($urandom_range(0, W + 1)),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(1, 4)));
      if ($urandom_range(0, 19) == 0)
        run_plan(int'($urandom_range(1, plan.size() - 1)));
      else
        run_plan(-1);
    end

    // Final cycle after the last boundary must be FETCH or IDLE with the pulse checks.
    build_plan(4, 6'h02, 0, 0, 0);   run_plan(-1);
    check_eq("final_state", 32'(state), 32'(0));
    check_eq("final_done", 32'(instr_done), 32'(1));
    check_eq("final_count", retired_count, model_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
